// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch (IFU) and load/store (LSU).
// Only one transaction is in flight at a time; the response is routed back to the requester that owns it.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  logic          owner_lsu;
  logic [SW-1:0] starve;
  logic          grant_lsu, grant_ifu, accept, rsp_fire;

  // LSU wins ties until the IFU has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || starve != STARVE_LIM);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  // Readies are forced low while reset is asserted so no requester sees a spurious accept.
  assign accept        = i_rst_n && (state == IDLE) && (ifu_req_valid || lsu_req_valid);
  assign ifu_req_ready = i_rst_n && (state == IDLE) && grant_ifu;
  assign lsu_req_ready = i_rst_n && (state == IDLE) && grant_lsu;
  assign mem_req_valid = (state == REQ);
  assign rsp_fire      = (state == WAIT) && mem_rsp_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ifu_req_valid || lsu_req_valid) state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the request/response registers are reset too, because outputs must read 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_lsu     <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else if (accept) begin
      owner_lsu     <= grant_lsu;
      mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
      mem_req_wen   <= grant_lsu && lsu_req_wen;
      mem_req_wdata <= (grant_lsu && lsu_req_wen) ? lsu_req_wdata : '0;
      mem_req_wmask <= (grant_lsu && lsu_req_wen) ? lsu_req_wmask : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (!ifu_req_valid || grant_ifu)          starve <= '0;
      else if (grant_lsu && starve != STARVE_LIM) starve <= starve + 1'b1;
    end
  end

  // Response data is held between transactions; only the owner's pulse fires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      lsu_rsp_data  <= '0;
    end else begin
      ifu_rsp_valid <= rsp_fire && !owner_lsu;
      lsu_rsp_valid <= rsp_fire && owner_lsu;
      if (rsp_fire && !owner_lsu) ifu_rsp_data <= mem_rsp_data;
      if (rsp_fire && owner_lsu)  lsu_rsp_data <= mem_req_wen ? '0 : mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [7:0]  mem_req_wmask;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction accepted but not yet handed to memory (pending),
  // one handed over and awaiting data (in_flight), and a response due to appear now (rsp_due).
  bit          pending, in_flight, rsp_due, rsp_to_lsu;
  int          starve;
  bit          t_lsu, t_wen;
  logic [31:0] t_addr, t_wdata, last_ifu, last_lsu;
  logic [7:0]  t_mask;

  bit          obs_ifu_rdy, obs_lsu_rdy, obs_ifu_rsp, obs_lsu_rsp, obs_mvalid, obs_wen;
  logic [31:0] obs_ifu_data, obs_lsu_data, obs_addr;
  logic [7:0]  obs_mask;

  task automatic model_reset();
    pending = 0; in_flight = 0; rsp_due = 0; rsp_to_lsu = 0;
    starve = 0; last_ifu = '0; last_lsu = '0;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // One clock: inputs are already applied (at the falling edge); check, advance model, advance clock.
  task automatic step();
    bit free, win_lsu, win_ifu;
    #1;
    obs_ifu_rdy = ifu_req_ready; obs_lsu_rdy = lsu_req_ready;
    obs_ifu_rsp = ifu_rsp_valid; obs_lsu_rsp = lsu_rsp_valid;
    obs_ifu_data = ifu_rsp_data; obs_lsu_data = lsu_rsp_data;
    obs_mvalid = mem_req_valid; obs_wen = mem_req_wen; obs_mask = mem_req_wmask; obs_addr = mem_req_addr;

    free = !pending && !in_flight;
    if (ifu_req_valid && lsu_req_valid) begin
      win_ifu = (starve >= STARVE_MAX);
      win_lsu = !win_ifu;
    end else begin
      win_ifu = ifu_req_valid;
      win_lsu = lsu_req_valid;
    end
    check("ifu_req_ready", ifu_req_ready, free && win_ifu);
    check("lsu_req_ready", lsu_req_ready, free && win_lsu);
    check("mem_req_valid", mem_req_valid, pending);
    if (pending) begin
      check("mem_req_addr",  mem_req_addr,  t_addr);
      check("mem_req_wen",   mem_req_wen,   t_wen);
      check("mem_req_wdata", mem_req_wdata, t_wdata);
      check("mem_req_wmask", mem_req_wmask, t_mask);
    end
    check("ifu_rsp_valid", ifu_rsp_valid, rsp_due && !rsp_to_lsu);
    check("lsu_rsp_valid", lsu_rsp_valid, rsp_due && rsp_to_lsu);
    check("ifu_rsp_data",  ifu_rsp_data,  last_ifu);
    check("lsu_rsp_data",  lsu_rsp_data,  last_lsu);

    rsp_due = 0;
    if (in_flight) begin
      if (mem_rsp_valid) begin
        in_flight = 0; rsp_due = 1; rsp_to_lsu = t_lsu;
        if (t_lsu) last_lsu = t_wen ? 32'h0 : mem_rsp_data;
        else       last_ifu = mem_rsp_data;
      end
    end else if (pending) begin
      if (mem_req_ready) begin
        pending = 0; in_flight = 1;
      end
    end else begin
      if (!ifu_req_valid || win_ifu) starve = 0;
      else if (win_lsu && starve < STARVE_MAX) starve++;
      if (win_ifu || win_lsu) begin
        pending = 1; t_lsu = win_lsu;
        t_addr  = win_lsu ? lsu_req_addr : ifu_req_addr;
        t_wen   = win_lsu && lsu_req_wen;
        t_wdata = t_wen ? lsu_req_wdata : 32'h0;
        t_mask  = t_wen ? lsu_req_wmask : 8'h0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_ifu_req_ready", ifu_req_ready, 0);
    check("rst_lsu_req_ready", lsu_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    check("rst_ifu_rsp_data",  ifu_rsp_data,  0);
    check("rst_lsu_rsp_data",  lsu_rsp_data,  0);
    check("rst_mem_req_addr",  mem_req_addr,  0);
    check("rst_mem_req_wmask", mem_req_wmask, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Let any outstanding transaction finish with requesters quiet.
  task automatic drain();
    clear_inputs();
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = $urandom;
    repeat (4) step();
    clear_inputs();
    step();
  endtask

  initial begin
    int  n_lsu;
    bit  ifu_got;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    do_reset();
    step();

    // IFU fetch alone, memory answers two cycles after accept.
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    step();
    check("ifu_only_accept", obs_ifu_rdy, 1);
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    check("ifu_only_mem_valid", obs_mvalid, 1);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0413;
    step();
    mem_rsp_valid = 0;
    step();
    check("ifu_only_rsp_pulse", obs_ifu_rsp, 1);
    check("ifu_only_rsp_data",  obs_ifu_data, 32'h0000_0413);
    check("ifu_only_lsu_quiet", obs_lsu_rsp, 0);
    step();
    check("ifu_only_pulse_end", obs_ifu_rsp, 0);

    // Simultaneous requests with no starvation history: LSU first, IFU next round.
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0200;
    step();
    check("tie_lsu_first", obs_lsu_rdy, 1);
    check("tie_ifu_waits", obs_ifu_rdy, 0);
    lsu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
    ifu_got = 0;
    for (int i = 0; i < 10 && !ifu_got; i++) begin
      step();
      if (obs_ifu_rdy) ifu_got = 1;
    end
    check("tie_ifu_next_round", ifu_got, 1);
    drain();

    // Starvation limit: LSU always requesting, IFU always waiting.
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0080;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0300;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h5555_aaaa;
    n_lsu = 0; ifu_got = 0;
    for (int i = 0; i < 40 && !ifu_got; i++) begin
      step();
      if (obs_lsu_rdy) n_lsu++;
      if (obs_ifu_rdy) ifu_got = 1;
    end
    check("starve_lsu_grants", n_lsu, STARVE_MAX);
    check("starve_ifu_granted", ifu_got, 1);
    drain();

    // LSU store with memory stalling three cycles; LSU keeps asking meanwhile.
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_0104;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    step();
    check("store_accept", obs_lsu_rdy, 1);
    lsu_req_addr = 32'h8000_0500; lsu_req_wdata = 32'h0BAD_0BAD;
    repeat (3) begin
      step();
      check("store_stall_valid", obs_mvalid, 1);
      check("store_stall_addr",  obs_addr, 32'h8000_0104);
      check("store_stall_wen",   obs_wen, 1);
      check("store_stall_mask",  obs_mask, 8'h0F);
      check("store_no_accept",   obs_lsu_rdy, 0);
    end
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    step();
    mem_rsp_valid = 0;
    step();
    check("store_ack_pulse", obs_lsu_rsp, 1);
    check("store_ack_data",  obs_lsu_data, 0);
    step();

    // Stray memory responses while idle must not reach either requester.
    mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF_0000;
    repeat (3) begin
      step();
      check("stray_ifu_rsp", obs_ifu_rsp, 0);
      check("stray_lsu_rsp", obs_lsu_rsp, 0);
    end
    clear_inputs();
    step();
    step();

    // Reset while waiting for memory, then a fresh LSU load completes.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0020;
    step();
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    clear_inputs();
    do_reset();
    step();
    check("post_rst_no_pulse", obs_lsu_rsp, 0);
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0010;
    step();
    check("post_rst_accept", obs_lsu_rdy, 1);
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 0;
    step();
    check("post_rst_rsp_pulse", obs_lsu_rsp, 1);
    check("post_rst_rsp_data",  obs_lsu_data, 32'hCAFE_F00D);

    // Randomized traffic, including responses arriving outside the wait phase.
    for (int i = 0; i < 3000; i++) begin
      ifu_req_valid = ($urandom_range(0, 3) != 0);
      ifu_req_addr  = $urandom;
      lsu_req_valid = ($urandom_range(0, 3) != 0);
      lsu_req_addr  = $urandom;
      lsu_req_wen   = $urandom_range(0, 1);
      lsu_req_wdata = $urandom;
      lsu_req_wmask = 8'($urandom);
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_data  = $urandom;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
